// File: rtl/key_pkg.sv
// Shared definitions for the key front end and the downstream 4-to-2 encoder.
//   NUM_KEYS          number of key channels
//   DEBOUNCE_DEFAULT  default debounce length in clock cycles
//   key_vec_t         one bit per key channel
//   key_idx_t         channel index, as used by the encoder stage
//   rr_pick           round-robin search helper
package key_pkg;

  localparam int NUM_KEYS         = 4;
  localparam int DEBOUNCE_DEFAULT = 16;

  typedef logic [NUM_KEYS-1:0] key_vec_t;
  typedef logic [1:0]          key_idx_t;

  // First set bit of req, searching upward from last+1 and wrapping.
  // Returns last when req is empty; callers qualify with req != 0.
  function automatic key_idx_t rr_pick(input key_vec_t req, input key_idx_t last);
    key_idx_t pick;
    key_idx_t cand;
    logic     found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_KEYS; i++) begin
      cand = key_idx_t'(last + key_idx_t'(i));
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchroniser followed by a counting debouncer.
//   clk, rst_n  clock and synchronous active-low reset
//   key         raw asynchronous key level (1 = pressed)
//   stable      debounced key level
//   press       high during the cycle whose edge moves stable from 0 to 1
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic stable,
  output logic press
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             accept;

  assign differs = (s2 != stable);
  assign accept  = differs && (cnt == LIMIT);
  // Combinational so the top can capture the press on the same edge
  // that updates stable.
  assign press   = accept && s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      // synchroniser
      s1 <= key;
      s2 <= s1;
      // debounce: any return to the stable level restarts the count
      if (!differs) begin
        cnt <= '0;
      end else if (accept) begin
        cnt    <= '0;
        stable <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Four-channel key front end feeding the 4-to-2 encoder. Debounced presses
// are queued as pending bits and issued one at a time, round-robin, as a
// registered one-hot word behind a valid/ready handshake.
//   clk, rst_n  clock and synchronous active-low reset
//   key_in      raw asynchronous key levels (1 = pressed)
//   ev_onehot   issued event, 0000 whenever ev_valid is low
//   ev_valid    an event is presented on ev_onehot
//   ev_ready    consumer accepts; transfer when ev_valid & ev_ready
//   pending     debounced presses captured but not yet issued
//   overrun     sticky: a press arrived while the channel was already pending
module key_event_arbiter
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic [3:0] ev_onehot,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [3:0] pending,
  output logic [3:0] overrun
);

  key_vec_t stable_vec;
  key_vec_t press_vec;
  key_vec_t new_press;
  key_idx_t ptr;
  key_idx_t pick;
  logic     free;
  logic     grant;
  key_vec_t grant_mask;
  key_vec_t pending_nxt;
  key_vec_t overrun_nxt;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (key_in[g]),
      .stable(stable_vec[g]),
      .press (press_vec[g])
    );
  end

  // A press is only ever a rise out of the released state.
  assign new_press = press_vec & ~stable_vec;

  always_comb begin
    free        = !ev_valid || ev_ready;
    grant       = free && (pending != '0);
    pick        = rr_pick(pending, ptr);
    grant_mask  = '0;
    grant_mask[pick] = grant;
    // A press landing on the channel being granted starts a fresh event,
    // so the granted bit is excluded from the overrun test.
    pending_nxt = (pending & ~grant_mask) | new_press;
    overrun_nxt = overrun | (new_press & pending & ~grant_mask);
  end

  // capture and output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      overrun   <= '0;
      ev_valid  <= 1'b0;
      ev_onehot <= '0;
      ptr       <= key_idx_t'(NUM_KEYS - 1);
    end else begin
      pending <= pending_nxt;
      overrun <= overrun_nxt;
      if (free) begin
        ev_valid  <= grant;
        ev_onehot <= grant_mask;
        if (grant) begin
          ptr <= pick;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
module tb_key_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] ev_onehot;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] pending;
  logic [3:0] overrun;

  int total;
  int bad;
  int xfers;
  logic [3:0] sb[$];

  key_event_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .ev_onehot(ev_onehot),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .pending  (pending),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every transfer must match the next expected event.
  always @(negedge clk) begin
    logic [3:0] exp;
    if (rst_n) begin
      total++;
      if (!ev_valid && ev_onehot !== 4'b0000) begin
        bad++;
        $display("FAIL idle_onehot got=%b want=0000", ev_onehot);
      end else if (ev_valid && $countones(ev_onehot) != 1) begin
        bad++;
        $display("FAIL onehot_shape got=%b want=single hot bit", ev_onehot);
      end
      if (ev_valid && ev_ready) begin
        xfers++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_xfer got=%b want=no transfer", ev_onehot);
        end else begin
          exp = sb.pop_front();
          if (ev_onehot !== exp) begin
            bad++;
            $display("FAIL xfer_order got=%b want=%b", ev_onehot, exp);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    key_in   = 4'b0000;
    ev_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({ev_onehot, ev_valid, pending, overrun} !== 13'b0) begin
        bad++;
        $display("FAIL reset_idle cycle=%0d got=%b%b%b%b want=all zero",
                 i, ev_onehot, ev_valid, pending, overrun);
      end
    end
  endtask

  task automatic test_clean_press();
    int first;
    int vcnt;
    logic [3:0] first_oh;
    ev_ready = 1'b1;
    first    = -1;
    vcnt     = 0;
    first_oh = 4'b0000;
    @(posedge clk);
    #1 key_in[2] = 1'b1;
    sb.push_back(4'b0100);
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (ev_valid) begin
        if (first < 0) begin
          first    = n;
          first_oh = ev_onehot;
        end
        vcnt++;
      end
    end
    total++;
    if (first != 19) begin
      bad++;
      $display("FAIL press_latency got=%0d want=19", first);
    end
    total++;
    if (first_oh !== 4'b0100) begin
      bad++;
      $display("FAIL press_onehot got=%b want=0100", first_oh);
    end
    total++;
    if (vcnt != 1) begin
      bad++;
      $display("FAIL press_valid_len got=%0d want=1", vcnt);
    end
    total++;
    if (pending !== 4'b0000) begin
      bad++;
      $display("FAIL press_pending got=%b want=0000", pending);
    end
    key_in[2] = 1'b0;
    wait_cycles(25);
  endtask

  task automatic test_glitch();
    int x0;
    ev_ready = 1'b1;
    x0 = xfers;
    @(posedge clk);
    #1 key_in[1] = 1'b1;
    wait_cycles(15);
    key_in[1] = 1'b0;
    wait_cycles(30);
    total++;
    if (xfers != x0 || pending !== 4'b0000) begin
      bad++;
      $display("FAIL glitch15 got=xfers %0d pending %b want=xfers 0 pending 0000",
               xfers - x0, pending);
    end
    x0 = xfers;
    sb.push_back(4'b0010);
    key_in[1] = 1'b1;
    wait_cycles(16);
    key_in[1] = 1'b0;
    wait_cycles(30);
    total++;
    if (xfers - x0 != 1) begin
      bad++;
      $display("FAIL glitch16 got=%0d want=1 transfer", xfers - x0);
    end
  endtask

  task automatic test_round_robin();
    logic held;
    int x0;
    do_reset();
    @(posedge clk);
    #1 key_in = 4'b1011;
    wait_cycles(30);
    total++;
    if (ev_valid !== 1'b1 || ev_onehot !== 4'b0001 || pending !== 4'b1010) begin
      bad++;
      $display("FAIL rr_first got=v%b oh=%b pend=%b want=v1 oh=0001 pend=1010",
               ev_valid, ev_onehot, pending);
    end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (ev_valid !== 1'b1 || ev_onehot !== 4'b0001) held = 1'b0;
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL rr_hold got=%b want=0001 held", ev_onehot);
    end
    sb.push_back(4'b0001);
    sb.push_back(4'b0010);
    sb.push_back(4'b1000);
    x0 = xfers;
    ev_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (ev_onehot !== 4'b0010 || ev_valid !== 1'b1) begin
      bad++;
      $display("FAIL rr_second got=%b want=0010", ev_onehot);
    end
    @(posedge clk);
    #1;
    total++;
    if (ev_onehot !== 4'b1000 || ev_valid !== 1'b1) begin
      bad++;
      $display("FAIL rr_third got=%b want=1000", ev_onehot);
    end
    @(posedge clk);
    #1;
    total++;
    if (ev_valid !== 1'b0) begin
      bad++;
      $display("FAIL rr_drain got=%b want=0", ev_valid);
    end
    total++;
    if (xfers - x0 != 3) begin
      bad++;
      $display("FAIL rr_count got=%0d want=3", xfers - x0);
    end
    key_in = 4'b0000;
    wait_cycles(25);
  endtask

  task automatic test_overrun();
    int x0;
    do_reset();
    key_in[0] = 1'b1;
    wait_cycles(25);
    key_in[3] = 1'b1;
    wait_cycles(25);
    key_in[3] = 1'b0;
    wait_cycles(25);
    key_in[3] = 1'b1;
    wait_cycles(25);
    total++;
    if (overrun !== 4'b1000 || pending !== 4'b1000) begin
      bad++;
      $display("FAIL overrun_set got=ovr %b pend %b want=ovr 1000 pend 1000",
               overrun, pending);
    end
    sb.push_back(4'b0001);
    sb.push_back(4'b1000);
    x0 = xfers;
    ev_ready = 1'b1;
    wait_cycles(10);
    total++;
    if (xfers - x0 != 2 || pending !== 4'b0000) begin
      bad++;
      $display("FAIL overrun_merge got=xfers %0d pend %b want=xfers 2 pend 0000",
               xfers - x0, pending);
    end
    total++;
    if (overrun !== 4'b1000) begin
      bad++;
      $display("FAIL overrun_sticky got=%b want=1000", overrun);
    end
    key_in = 4'b0000;
    wait_cycles(25);
  endtask

  task automatic test_reset_mid();
    int x0;
    do_reset();
    key_in = 4'b0001;
    wait_cycles(25);
    key_in = 4'b0111;
    wait_cycles(25);
    total++;
    if (pending !== 4'b0110 || ev_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_setup got=pend %b v%b want=pend 0110 v1", pending, ev_valid);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    key_in = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    total++;
    if (pending !== 4'b0000 || ev_valid !== 1'b0 || overrun !== 4'b0000 ||
        ev_onehot !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset got=pend %b v%b ovr %b oh %b want=all zero",
               pending, ev_valid, overrun, ev_onehot);
    end
    x0 = xfers;
    ev_ready = 1'b1;
    wait_cycles(30);
    total++;
    if (xfers != x0) begin
      bad++;
      $display("FAIL mid_after got=%0d want=0 transfers", xfers - x0);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    xfers    = 0;
    rst_n    = 1'b0;
    key_in   = 4'b0000;
    ev_ready = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_round_robin();
    test_overrun();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
